usb_nrzi_rx_decoder: RTL and testbench

Receive-side USB line decoder.
- Takes the sampled line level once per bit strobe and NRZI-decodes it.
- Removes stuffed bits after STUFF_LEN consecutive ones and flags stuffing violations.
- Deserialises LSB-first into DATA_W-bit words for the RX packet FSM.
- Sits between the edge/sync sampler (supplies d_high, shift_enable, eop) and the RX control/FIFO logic.

---
 rtl/usb_nrzi_rx_decoder.sv | 81 ++++++++
 tb/tb_usb_nrzi_rx_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/usb_nrzi_rx_decoder.sv
// usb_nrzi_rx_decoder: NRZI decode, bit unstuffing and LSB-first deserialising of the USB RX line; define USB_RX_ERRCNT_EN to add err_count
module usb_nrzi_rx_decoder #(
  parameter int STUFF_LEN = 6,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_high,
  input  logic              shift_enable,
  input  logic              eop,
  input  logic              clear,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              stuff_err,
  output logic              align_err
`ifdef USB_RX_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);
  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  logic              r_prev;
  logic [ONES_W-1:0] r_ones;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic              w_raw, w_stuff, w_restart, w_shift, w_emit, w_done;
  logic              w_stuff_err, w_align_err;
  logic [DATA_W-1:0] w_shreg_nx;
  assign w_raw       = ~(d_high ^ r_prev);
  assign w_stuff     = r_ones == ONES_W'(STUFF_LEN);
  assign w_restart   = clear | (shift_enable & eop);
  assign w_shift     = shift_enable & ~eop & ~clear;
  assign w_emit      = w_shift & ~w_stuff;
  assign w_done      = w_emit & (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_shreg_nx  = {w_raw, r_shreg[DATA_W-1:1]};
  assign w_stuff_err = w_shift & w_stuff & w_raw;
  assign w_align_err = ~clear & shift_enable & eop & (r_bit_cnt != '0);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_prev     <= 1'b1;
      r_ones     <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      bit_out    <= 1'b1;
      bit_valid  <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      stuff_err  <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      bit_valid  <= w_emit;
      word_valid <= w_done;
      stuff_err  <= w_stuff_err;
      align_err  <= w_align_err;
      if (w_restart) begin
        r_prev    <= 1'b1;
        r_ones    <= '0;
        r_bit_cnt <= '0;
        r_shreg   <= '0;
      end else if (w_shift) begin
        r_prev <= d_high;
        // a stuffed position always restarts the run, whether or not it was a legal zero
        r_ones <= (w_stuff | ~w_raw) ? '0 : r_ones + ONES_W'(1);
        if (w_emit) begin
          bit_out   <= w_raw;
          r_shreg   <= w_shreg_nx;
          r_bit_cnt <= w_done ? '0 : r_bit_cnt + CNT_W'(1);
        end
        if (w_done) word_out <= w_shreg_nx;
      end
    end
`ifdef USB_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) err_count <= '0;
    else if (clear) err_count <= '0;
    else if ((w_stuff_err | w_align_err) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_usb_nrzi_rx_decoder.sv
// tb_usb_nrzi_rx_decoder: directed-vector bench for the USB NRZI RX decoder
module tb_usb_nrzi_rx_decoder;
  logic       clk = 1'b0, n_rst = 1'b0, d_high = 1'b1, shift_enable = 1'b0, eop = 1'b0, clear = 1'b0;
  logic       bit_out, bit_valid, word_valid, stuff_err, align_err;
  logic [7:0] word_out;
`ifdef USB_RX_ERRCNT_EN
  logic [15:0] err_count;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  usb_nrzi_rx_decoder #(.STUFF_LEN(6), .DATA_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .d_high(d_high), .shift_enable(shift_enable), .eop(eop), .clear(clear),
    .bit_out(bit_out), .bit_valid(bit_valid), .word_out(word_out), .word_valid(word_valid),
    .stuff_err(stuff_err), .align_err(align_err)
`ifdef USB_RX_ERRCNT_EN
    , .err_count(err_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic se, input logic d, input logic e, input logic c);
    shift_enable = se;
    d_high = d;
    eop = e;
    clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string tag);
    chk({tag, ".bit_valid"}, bit_valid, 0);
    chk({tag, ".word_valid"}, word_valid, 0);
    chk({tag, ".stuff_err"}, stuff_err, 0);
    chk({tag, ".align_err"}, align_err, 0);
  endtask
  // d[i] is the i-th line level sent; exp is both the decoded bit sequence and the resulting word
  task automatic send8(input string tag, input logic [7:0] d, input logic [7:0] exp, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, d[i], 1'b0, 1'b0);
      chk({tag, ".bit_valid"}, bit_valid, 1);
      chk({tag, ".bit_out"}, bit_out, exp[i]);
      chk({tag, ".word_valid"}, word_valid, i == 7);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, g[0] ^ d[i], 1'b0, 1'b0);
        chk({tag, ".gap_bit_valid"}, bit_valid, 0);
      end
    end
    chk({tag, ".word_out"}, word_out, exp);
  endtask
  initial begin
    #12;
    chk("reset.bit_out", bit_out, 1);
    chk("reset.word_out", word_out, 8'h00);
    quiet("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    send8("basic", 8'h2A, 8'h80, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    quiet("clear1");
    chk("clear1.word_out_kept", word_out, 8'h80);
    chk("clear1.bit_out_kept", bit_out, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("unstuff.bit_valid", bit_valid, 1);
      chk("unstuff.bit_out", bit_out, 1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("unstuff.stuffed_bit_valid", bit_valid, 0);
    chk("unstuff.stuff_err", stuff_err, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("unstuff.bit7_valid", bit_valid, 1);
    chk("unstuff.word_valid7", word_valid, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("unstuff.bit8_out", bit_out, 1);
    chk("unstuff.word_valid8", word_valid, 1);
    chk("unstuff.word_out", word_out, 8'hFF);
    chk("unstuff.stuff_err_end", stuff_err, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("stufferr.bit_valid", bit_valid, 1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("stufferr.stuff_err", stuff_err, 1);
    chk("stufferr.bit_valid7", bit_valid, 0);
`ifdef USB_RX_ERRCNT_EN
    chk("stufferr.err_count", err_count, 1);
`endif
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("stufferr.ones_restart_bit_valid", bit_valid, 1);
    chk("stufferr.ones_restart_stuff_err", stuff_err, 0);
    chk("stufferr.word_valid_not_yet", word_valid, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stufferr.word_valid", word_valid, 1);
    chk("stufferr.word_out", word_out, 8'h7F);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef USB_RX_ERRCNT_EN
    chk("clear.err_count", err_count, 0);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    quiet("eop_no_strobe");
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("eop.align_err", align_err, 1);
    chk("eop.bit_valid", bit_valid, 0);
    chk("eop.word_valid", word_valid, 0);
`ifdef USB_RX_ERRCNT_EN
    chk("eop.err_count", err_count, 1);
`endif
    send8("after_eop", 8'h2A, 8'h80, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    quiet("eop_aligned");
    send8("gaps", 8'hB9, 8'h35, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    quiet("clear_eop");
    send8("after_clear", 8'h2A, 8'h80, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_reset.word_valid", word_valid, 0);
    for (int i = 0; i < 5; i++) step(1'b1, i[0] ? 1'b1 : 1'b0, 1'b0, 1'b0);
    chk("pre_reset.bit_out", bit_out, 0);
    chk("pre_reset.bit_valid", bit_valid, 1);
    shift_enable = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("async_reset.bit_out", bit_out, 1);
    chk("async_reset.word_out", word_out, 8'h00);
    quiet("async_reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    send8("after_reset", 8'h2A, 8'h80, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
